// File: rtl/pattern_tx_if.sv
// Handshake and serial-output bundle between a frame requester and pattern_tx.
interface pattern_tx_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              out;
  logic              frame_end;

  modport master (output start, output data, input ready, input out, input frame_end);
  modport slave  (input start, input data, output ready, output out, output frame_end);
endinterface

// File: rtl/pattern_tx.sv
// Serial frame transmitter: sync pattern, MSB-first payload, then idle gap zeros.
// Every output is a flop loaded from the next-state decode, so bits appear the cycle after the edge.
module pattern_tx #(
  parameter int                SYNC_W = 6,
  parameter logic [SYNC_W-1:0] SYNC   = 6'b110101,
  parameter int                DATA_W = 8,
  parameter int                GAP    = 2
) (
  input  logic       clk,
  input  logic       rst,
  pattern_tx_if.slave bus
);

  localparam int M1 = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int M2 = (M1 > GAP) ? M1 : GAP;
  localparam int M3 = (M2 > 2) ? M2 : 2;
  localparam int CW = $clog2(M3);

  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              out_q, out_d;
  logic              ready_q, ready_d;
  logic              fend_q, fend_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      out_q   <= 1'b0;
      ready_q <= 1'b1;
      fend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      fend_q  <= fend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SYNC;
          cnt_d   = SYNC_LAST;
          shift_d = bus.data;
        end
      end
      S_SYNC: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = DATA_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          state_d = (GAP > 0) ? S_GAP : S_IDLE;
          cnt_d   = GAP_LAST;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          shift_d = shift_q << 1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the state being entered so the registered bit lines up with it.
  always_comb begin
    out_d   = 1'b0;
    ready_d = (state_d == S_IDLE);
    fend_d  = (state_d == S_DATA) && (cnt_d == '0);
    case (state_d)
      S_SYNC:  out_d = SYNC[cnt_d];
      S_DATA:  out_d = shift_d[DATA_W-1];
      default: out_d = 1'b0;
    endcase
  end

  assign bus.out       = out_q;
  assign bus.ready     = ready_q;
  assign bus.frame_end = fend_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: reset, single/back-to-back frames, ignored requests, abort, loopback detect.
module tb_pattern_tx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pattern_tx_if #(.DATA_W(8)) bus ();

  pattern_tx #(.SYNC_W(6), .SYNC(6'b110101), .DATA_W(8), .GAP(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         total = 0;
  int         bad   = 0;
  logic [5:0] det_sh;
  int         det_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts a frame on the next edge, then checks cycles 1..17 and returns in cycle 17 (idle).
  // hold=1 keeps start high; otherwise start is pulsed mid-frame and must be ignored.
  task automatic run_frame(input logic [7:0] d, input bit hold, input string nm);
    logic [5:0] sp;
    logic       e_out;
    sp = 6'b110101;
    bus.start = 1'b1;
    bus.data  = d;
    tick();
    bus.data = ~d;
    if (!hold) bus.start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c <= 6)       e_out = sp[3'(6 - c)];
      else if (c <= 14) e_out = d[3'(14 - c)];
      else              e_out = 1'b0;
      chk($sformatf("%s out c%0d", nm, c),  32'(bus.out),       32'(e_out));
      chk($sformatf("%s fend c%0d", nm, c), 32'(bus.frame_end), 32'(c == 14));
      chk($sformatf("%s rdy c%0d", nm, c),  32'(bus.ready),     32'(c == 17));
      det_sh = {det_sh[4:0], bus.out};
      if (det_sh == 6'b110101) det_cyc.push_back(c);
      if (c < 17) begin
        if (!hold) bus.start = (c == 3) || (c == 9);
        tick();
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    det_sh = '0;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.data  = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst out",  32'(bus.out),       32'd0);
      chk("rst rdy",  32'(bus.ready),     32'd1);
      chk("rst fend", 32'(bus.frame_end), 32'd0);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("post-rst out", 32'(bus.out),   32'd0);
    chk("post-rst rdy", 32'(bus.ready), 32'd1);

    // Single frame with mid-frame start pulses and data changes
    run_frame(8'hA5, 1'b0, "a5");
    tick();
    chk("noqueue rdy", 32'(bus.ready), 32'd1);
    chk("noqueue out", 32'(bus.out),   32'd0);

    // Start held high: frames follow each other through the single idle cycle
    run_frame(8'hFF, 1'b1, "b0");
    run_frame(8'h00, 1'b1, "b1");
    run_frame(8'hFF, 1'b1, "b2");
    bus.start = 1'b0;
    tick();
    chk("b2b end rdy", 32'(bus.ready), 32'd1);
    chk("b2b end out", 32'(bus.out),   32'd0);

    // Abort in cycle 9
    bus.start = 1'b1;
    bus.data  = 8'hFF;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("pre-abort out c9", 32'(bus.out), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort out",  32'(bus.out),       32'd0);
    chk("abort rdy",  32'(bus.ready),     32'd1);
    chk("abort fend", 32'(bus.frame_end), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("abort idle fend %0d", i), 32'(bus.frame_end), 32'd0);
      chk($sformatf("abort idle out %0d", i),  32'(bus.out),       32'd0);
    end
    run_frame(8'h3C, 1'b0, "post");

    // Loopback: detector must fire at end of sync and end of payload only
    tick();
    det_sh = '0;
    det_cyc.delete();
    run_frame(8'h35, 1'b0, "lb");
    for (int i = 0; i < 3; i++) begin
      tick();
      det_sh = {det_sh[4:0], bus.out};
      if (det_sh == 6'b110101) det_cyc.push_back(18 + i);
    end
    chk("lb hits",  32'(det_cyc.size()), 32'd2);
    chk("lb hit0",  (det_cyc.size() > 0) ? 32'(det_cyc[0]) : 32'hFFFF, 32'd6);
    chk("lb hit1",  (det_cyc.size() > 1) ? 32'(det_cyc[1]) : 32'hFFFF, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
